// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential restoring divider, one quotient bit per clock
module seq_restoring_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic                  dz_q, dz_d;

    // dvd_q shifts the dividend out of its MSB while quotient bits enter at the LSB.
    logic [DIVISOR_W:0]    r_shift;
    logic [DIVISOR_W-1:0]  r_sub;
    logic                  q_bit;

    assign r_shift = {rem_q, dvd_q[DIVIDEND_W-1]};
    assign q_bit   = (r_shift >= {1'b0, dsr_q});
    assign r_sub   = r_shift[DIVISOR_W-1:0] - dsr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dsr_d   = divisor;
                    state_d = S_BUSY;
                    if (divisor == '0) begin
                        // Divide-by-zero spends a single pass through BUSY with the result preloaded.
                        dvd_d = '1;
                        rem_d = dividend[DIVISOR_W-1:0];
                        dz_d  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        dvd_d = dividend;
                        rem_d = '0;
                        dz_d  = 1'b0;
                        cnt_d = CNT_LAST;
                    end
                end
            end
            S_BUSY: begin
                if (!dz_q) begin
                    rem_d = q_bit ? r_sub : r_shift[DIVISOR_W-1:0];
                    dvd_d = {dvd_q[DIVIDEND_W-2:0], q_bit};
                end
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign quotient  = dvd_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed and randomized bench for seq_restoring_divider
module tb_seq_restoring_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    seq_restoring_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic do_div(input logic [15:0] a, input logic [7:0] b, input int gap_out,
                          output logic [15:0] q, output logic [7:0] r, output logic dz,
                          output int lat, output logic to);
        int guard;
        to = 1'b0; lat = 0; q = '0; r = '0; dz = 1'b0;
        @(negedge clk);
        dividend = a; divisor = b; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            to = 1'b1; in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            to = 1'b1;
            return;
        end
        q = quotient; r = remainder; dz = div_zero;
        repeat (gap_out) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'h0 ||
            remainder !== 8'h0 || div_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset: rdy=%b vld=%b q=%h r=%h dz=%b required rdy=1 vld=0 q=0 r=0 dz=0",
                     in_ready, out_valid, quotient, remainder, div_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [15:0] ta [5] = '{16'd65025, 16'd1000, 16'd100, 16'hFFFF, 16'd0};
        logic [7:0]  tb [5] = '{8'd255, 8'd7, 8'd200, 8'd1, 8'd9};
        logic [15:0] tq [5] = '{16'd255, 16'd142, 16'd0, 16'hFFFF, 16'd0};
        logic [7:0]  tr [5] = '{8'd0, 8'd6, 8'd100, 8'd0, 8'd0};
        logic [15:0] q; logic [7:0] r; logic dz; int lat; logic to;
        for (int i = 0; i < 5; i++) begin
            do_div(ta[i], tb[i], 0, q, r, dz, lat, to);
            total++;
            if (to) begin
                bad++;
                $display("FAIL basic_timeout[%0d]: no result for %0d/%0d", i, ta[i], tb[i]);
                continue;
            end
            total++;
            if (q !== tq[i]) begin
                bad++;
                $display("FAIL basic_q[%0d]: got %0d required %0d", i, q, tq[i]);
            end
            total++;
            if (r !== tr[i]) begin
                bad++;
                $display("FAIL basic_r[%0d]: got %0d required %0d", i, r, tr[i]);
            end
            total++;
            if (dz !== 1'b0) begin
                bad++;
                $display("FAIL basic_dz[%0d]: got %b required 0", i, dz);
            end
            total++;
            if (lat != 16) begin
                bad++;
                $display("FAIL basic_latency[%0d]: got %0d required 16", i, lat);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [15:0] q; logic [7:0] r; logic dz; int lat; logic to;
        do_div(16'h1234, 8'd0, 0, q, r, dz, lat, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL dz_timeout: no result for 1234/0");
        end else begin
            total++;
            if (q !== 16'hFFFF || r !== 8'h34 || dz !== 1'b1) begin
                bad++;
                $display("FAIL dz_result: got q=%h r=%h dz=%b required q=ffff r=34 dz=1", q, r, dz);
            end
            total++;
            if (lat != 1) begin
                bad++;
                $display("FAIL dz_latency: got %0d required 1", lat);
            end
        end
    endtask

    task automatic test_backpressure;
        int guard;
        @(negedge clk);
        dividend = 16'd1000; divisor = 8'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (!out_valid) begin
            bad++;
            $display("FAIL bp_timeout: out_valid never rose");
            return;
        end
        for (int i = 0; i < 5; i++) begin
            dividend = 16'd100; divisor = 8'd200; in_valid = 1'b1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd142 || remainder !== 8'd6) begin
                bad++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b q=%0d r=%0d required vld=1 rdy=0 q=142 r=6",
                         i, out_valid, in_ready, quotient, remainder);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_not_queued: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] q; logic [7:0] r; logic dz; int lat; logic to;
        @(negedge clk);
        dividend = 16'd1000; divisor = 8'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_busy: rdy=%b required 0", in_ready);
        end
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 16'h0) begin
            bad++;
            $display("FAIL rst_mid_async: vld=%b rdy=%b q=%h required vld=0 rdy=1 q=0",
                     out_valid, in_ready, quotient);
        end
        @(negedge clk);
        rst = 1'b0;
        do_div(16'd81, 8'd9, 1, q, r, dz, lat, to);
        total++;
        if (to || q !== 16'd9 || r !== 8'd0 || dz !== 1'b0 || lat != 16) begin
            bad++;
            $display("FAIL rst_mid_after: to=%b q=%0d r=%0d dz=%b lat=%0d required q=9 r=0 dz=0 lat=16",
                     to, q, r, dz, lat);
        end
    endtask

    task automatic test_back_to_back;
        int acc [$];
        int nvalid = 0;
        int guard;
        @(negedge clk);
        dividend = 16'd65025; divisor = 8'd255; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (in_ready) acc.push_back(cyc);
            if (out_valid) begin
                nvalid++;
                total++;
                if (quotient !== 16'd255 || remainder !== 8'd0) begin
                    bad++;
                    $display("FAIL b2b_result: q=%0d r=%0d required q=255 r=0", quotient, remainder);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (acc.size() < 2 || nvalid < 2) begin
            bad++;
            $display("FAIL b2b_count: accepts=%0d results=%0d required >=2 each", acc.size(), nvalid);
        end else begin
            total++;
            if (acc[1] - acc[0] != 18) begin
                bad++;
                $display("FAIL b2b_period: got %0d required 18", acc[1] - acc[0]);
            end
        end
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [15:0] a, q; logic [7:0] b, r; logic dz; int lat; logic to;
        logic [31:0] chk;
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_div(a, b, $urandom_range(0, 2), q, r, dz, lat, to);
            total++;
            if (to) begin
                bad++;
                $display("FAIL rand_timeout[%0d]: %0d/%0d", i, a, b);
            end else if (b == 8'd0) begin
                if (q !== 16'hFFFF || r !== a[7:0] || dz !== 1'b1) begin
                    bad++;
                    $display("FAIL rand_dz[%0d]: %0d/0 got q=%h r=%h dz=%b required q=ffff r=%h dz=1",
                             i, a, q, r, dz, a[7:0]);
                end
            end else begin
                chk = {16'd0, q} * {24'd0, b} + {24'd0, r};
                if (chk !== {16'd0, a} || r >= b || dz !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_inv[%0d]: %0d/%0d got q=%0d r=%0d dz=%b required q*b+r=%0d r<%0d dz=0",
                             i, a, b, q, r, dz, a, b);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div_zero;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
